// File: rtl/bp_cce_mshr_sched_pkg.sv
// Shared types for the CCE multi-transaction MSHR scheduler.
// Slot lifecycle: FREE -> READY -> RUNNING -> (FREE | WAIT -> READY).
package bp_cce_mshr_sched_pkg;

    typedef enum logic [1:0] {
        e_slot_free    = 2'd0,
        e_slot_ready   = 2'd1,
        e_slot_running = 2'd2,
        e_slot_wait    = 2'd3
    } bp_cce_mshr_slot_state_e;

endpackage

// File: rtl/bp_cce_mshr_sched_if.sv
// Request/grant/completion bundle between LCE front end, microcode engine and scheduler.
interface bp_cce_mshr_sched_if #(
    parameter int num_mshr_p     = 4,
    parameter int paddr_width_p  = 40,
    parameter int lce_id_width_p = 4
) ();
    localparam int lg_num_mshr_lp = $clog2(num_mshr_p);

    logic                      alloc_v_i;
    logic [paddr_width_p-1:0]  alloc_paddr_i;
    logic [lce_id_width_p-1:0] alloc_lce_id_i;
    logic                      alloc_ready_o;
    logic [lg_num_mshr_lp-1:0] alloc_id_o;
    logic                      sched_v_o;
    logic [lg_num_mshr_lp-1:0] sched_id_o;
    logic [paddr_width_p-1:0]  sched_paddr_o;
    logic [lce_id_width_p-1:0] sched_lce_id_o;
    logic                      sched_yumi_i;
    logic                      suspend_i;
    logic                      done_i;
    logic                      mem_resp_v_i;
    logic [lg_num_mshr_lp-1:0] mem_resp_id_i;
    logic [lg_num_mshr_lp-1:0] active_id_o;
    logic                      busy_o;
    logic                      empty_o;
    logic                      full_o;
    logic                      error_o;

    modport master (
        output alloc_v_i, alloc_paddr_i, alloc_lce_id_i, sched_yumi_i,
               suspend_i, done_i, mem_resp_v_i, mem_resp_id_i,
        input  alloc_ready_o, alloc_id_o, sched_v_o, sched_id_o, sched_paddr_o,
               sched_lce_id_o, active_id_o, busy_o, empty_o, full_o, error_o
    );

    modport slave (
        input  alloc_v_i, alloc_paddr_i, alloc_lce_id_i, sched_yumi_i,
               suspend_i, done_i, mem_resp_v_i, mem_resp_id_i,
        output alloc_ready_o, alloc_id_o, sched_v_o, sched_id_o, sched_paddr_o,
               sched_lce_id_o, active_id_o, busy_o, empty_o, full_o, error_o
    );

endinterface

// File: rtl/bp_cce_mshr_sched_rr_pick.sv
// Round-robin pick: first set bit of ready_i at or after ptr_i, wrapping around.
module bp_cce_mshr_rr_pick #(
    parameter  int num_p     = 4,
    localparam int lg_num_lp = $clog2(num_p)
) (
    input  logic [num_p-1:0]     ready_i,
    input  logic [lg_num_lp-1:0] ptr_i,
    output logic                 v_o,
    output logic [lg_num_lp-1:0] id_o
);

    logic [lg_num_lp-1:0] w_idx;
    logic                 w_found;
    logic                 w_hit;

    // Walk from the pointer; index arithmetic wraps because num_p is a power of two.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_hit   = 1'b0;
        id_o    = '0;
        for (int i = 0; i < num_p; i++) begin
            w_idx   = ptr_i + lg_num_lp'(i);
            w_hit   = ~w_found & ready_i[w_idx];
            id_o    = w_hit ? w_idx : id_o;
            w_found = w_found | w_hit;
        end
    end

    assign v_o = |ready_i;

endmodule

// File: rtl/bp_cce_mshr_sched.sv
// MSHR slot scheduler: allocates slots to LCE requests, blocks same-block requests,
// and round-robin grants READY slots to the single microcode engine.
module bp_cce_mshr_sched
    import bp_cce_mshr_sched_pkg::*;
#(
    parameter int num_mshr_p               = 4,
    parameter int paddr_width_p            = 40,
    parameter int lce_id_width_p           = 4,
    parameter int lg_block_size_in_bytes_p = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_cce_mshr_sched_if.slave    io
);

    localparam int lg_lp = $clog2(num_mshr_p);

    bp_cce_mshr_slot_state_e   r_state [num_mshr_p];
    logic [paddr_width_p-1:0]  r_paddr [num_mshr_p];
    logic [lce_id_width_p-1:0] r_lce   [num_mshr_p];
    logic [lg_lp-1:0]          r_rr;
    logic                      r_error;

    logic [num_mshr_p-1:0] w_free, w_ready, w_running, w_conflict;
    logic [lg_lp-1:0]      w_alloc_id, w_active_id, w_sched_id;
    logic                  w_any_ready, w_busy, w_full, w_sched_v, w_alloc_ready;
    logic                  w_alloc_fire, w_grant, w_err_set;

    function automatic logic [lg_lp-1:0] lowest_set(input logic [num_mshr_p-1:0] vec);
        logic [lg_lp-1:0] res;
        res = '0;
        for (int i = num_mshr_p - 1; i >= 0; i--) begin
            res = vec[i] ? lg_lp'(i) : res;
        end
        return res;
    endfunction

    // Per-slot state decode and block-address conflict against the incoming request.
    always_comb begin
        w_free     = '0;
        w_ready    = '0;
        w_running  = '0;
        w_conflict = '0;
        for (int i = 0; i < num_mshr_p; i++) begin
            w_free[i]     = (r_state[i] == e_slot_free);
            w_ready[i]    = (r_state[i] == e_slot_ready);
            w_running[i]  = (r_state[i] == e_slot_running);
            w_conflict[i] = (r_state[i] != e_slot_free) &&
                (r_paddr[i][paddr_width_p-1:lg_block_size_in_bytes_p] ==
                 io.alloc_paddr_i[paddr_width_p-1:lg_block_size_in_bytes_p]);
        end
    end

    bp_cce_mshr_rr_pick #(.num_p(num_mshr_p)) u_rr_pick (
        .ready_i (w_ready),
        .ptr_i   (r_rr),
        .v_o     (w_any_ready),
        .id_o    (w_sched_id)
    );

    assign w_alloc_id    = lowest_set(w_free);
    assign w_active_id   = lowest_set(w_running);
    assign w_busy        = |w_running;
    assign w_full        = ~|w_free;
    assign w_sched_v     = ~w_busy & w_any_ready;
    // Held low during reset even though every slot already reads FREE.
    assign w_alloc_ready = reset_n_i & ~w_full & ~|w_conflict;
    assign w_alloc_fire  = io.alloc_v_i & w_alloc_ready;
    assign w_grant       = io.sched_yumi_i & w_sched_v;

    assign w_err_set = (io.sched_yumi_i & ~w_sched_v)
                     | ((io.done_i | io.suspend_i) & ~w_busy)
                     | (io.done_i & io.suspend_i)
                     | (io.mem_resp_v_i & (r_state[io.mem_resp_id_i] != e_slot_wait));

    // Slot lifecycle, payload capture, round-robin pointer and sticky error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_mshr_p; i++) begin
                r_state[i] <= e_slot_free;
                r_paddr[i] <= '0;
                r_lce[i]   <= '0;
            end
            r_rr    <= '0;
            r_error <= 1'b0;
        end else begin
            for (int i = 0; i < num_mshr_p; i++) begin
                case (r_state[i])
                    e_slot_free: begin
                        if (w_alloc_fire && (w_alloc_id == lg_lp'(i))) begin
                            r_state[i] <= e_slot_ready;
                            r_paddr[i] <= io.alloc_paddr_i;
                            r_lce[i]   <= io.alloc_lce_id_i;
                        end
                    end
                    e_slot_ready: begin
                        if (w_grant && (w_sched_id == lg_lp'(i))) begin
                            r_state[i] <= e_slot_running;
                        end
                    end
                    e_slot_running: begin
                        if (io.done_i) begin
                            r_state[i] <= e_slot_free;
                        end else if (io.suspend_i) begin
                            r_state[i] <= e_slot_wait;
                        end
                    end
                    e_slot_wait: begin
                        if (io.mem_resp_v_i && (io.mem_resp_id_i == lg_lp'(i))) begin
                            r_state[i] <= e_slot_ready;
                        end
                    end
                    default: r_state[i] <= e_slot_free;
                endcase
            end
            if (w_grant) begin
                r_rr <= w_sched_id + lg_lp'(1);
            end
            r_error <= r_error | w_err_set;
        end
    end

    assign io.alloc_ready_o  = w_alloc_ready;
    assign io.alloc_id_o     = w_alloc_id;
    assign io.sched_v_o      = w_sched_v;
    assign io.sched_id_o     = w_sched_id;
    assign io.sched_paddr_o  = r_paddr[w_sched_id];
    assign io.sched_lce_id_o = r_lce[w_sched_id];
    assign io.active_id_o    = w_active_id;
    assign io.busy_o         = w_busy;
    assign io.empty_o        = &w_free;
    assign io.full_o         = w_full;
    assign io.error_o        = r_error;

endmodule

// File: tb/tb_bp_cce_mshr_sched.sv
// Directed bench for bp_cce_mshr_sched: a per-cycle vector table plus short
// hand-written sequences for error, suspend/response and reset corner cases.
module tb_bp_cce_mshr_sched;
    import bp_cce_mshr_sched_pkg::*;

    localparam int NV = 25;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bp_cce_mshr_sched_if #(.num_mshr_p(4), .paddr_width_p(40), .lce_id_width_p(4)) io ();

    bp_cce_mshr_sched #(
        .num_mshr_p(4), .paddr_width_p(40), .lce_id_width_p(4), .lg_block_size_in_bytes_p(6)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .io        (io)
    );

    typedef struct {
        logic        a_v;
        logic [39:0] a_pa;
        logic [3:0]  a_lce;
        logic        yumi, susp, done, rv;
        logic [1:0]  rid;
        logic        e_ar;
        logic [1:0]  e_aid;
        logic        e_sv;
        logic [1:0]  e_sid;
        logic [39:0] e_spa;
        logic [3:0]  e_slce;
        logic        e_busy;
        logic [1:0]  e_act;
        logic        e_full, e_empty, e_err;
    } vec_t;

    vec_t vecs [NV];
    int   errs   = 0;
    int   checks = 0;

    function automatic vec_t mk(input int a_v, input longint pa, input int lce,
                                input int yumi, input int susp, input int done,
                                input int rv, input int rid,
                                input int ar, input int aid, input int sv, input int sid,
                                input longint spa, input int slce, input int busy,
                                input int act, input int full, input int empty, input int err);
        vec_t v;
        v.a_v = 1'(a_v);   v.a_pa = 40'(pa);   v.a_lce = 4'(lce);
        v.yumi = 1'(yumi); v.susp = 1'(susp);  v.done = 1'(done);
        v.rv = 1'(rv);     v.rid = 2'(rid);
        v.e_ar = 1'(ar);   v.e_aid = 2'(aid);  v.e_sv = 1'(sv);  v.e_sid = 2'(sid);
        v.e_spa = 40'(spa); v.e_slce = 4'(slce); v.e_busy = 1'(busy); v.e_act = 2'(act);
        v.e_full = 1'(full); v.e_empty = 1'(empty); v.e_err = 1'(err);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        io.alloc_v_i      = v.a_v;
        io.alloc_paddr_i  = v.a_pa;
        io.alloc_lce_id_i = v.a_lce;
        io.sched_yumi_i   = v.yumi;
        io.suspend_i      = v.susp;
        io.done_i         = v.done;
        io.mem_resp_v_i   = v.rv;
        io.mem_resp_id_i  = v.rid;
    endtask

    // Drive one cycle of inputs at the falling edge; outputs settle before the next rising edge.
    task automatic step(input int a_v, input longint pa, input int lce, input int yumi,
                        input int susp, input int done, input int rv, input int rid);
        @(negedge clk);
        drive(mk(a_v, pa, lce, yumi, susp, done, rv, rid, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
    endtask

    task automatic check_vec(input int k, input vec_t v);
        chk($sformatf("v%0d.alloc_ready", k), 64'(io.alloc_ready_o), 64'(v.e_ar));
        if (!v.e_full) chk($sformatf("v%0d.alloc_id", k), 64'(io.alloc_id_o), 64'(v.e_aid));
        chk($sformatf("v%0d.sched_v", k), 64'(io.sched_v_o), 64'(v.e_sv));
        if (v.e_sv) begin
            chk($sformatf("v%0d.sched_id", k), 64'(io.sched_id_o), 64'(v.e_sid));
            chk($sformatf("v%0d.sched_paddr", k), 64'(io.sched_paddr_o), 64'(v.e_spa));
            chk($sformatf("v%0d.sched_lce", k), 64'(io.sched_lce_id_o), 64'(v.e_slce));
        end
        chk($sformatf("v%0d.busy", k), 64'(io.busy_o), 64'(v.e_busy));
        if (v.e_busy) chk($sformatf("v%0d.active_id", k), 64'(io.active_id_o), 64'(v.e_act));
        chk($sformatf("v%0d.full", k), 64'(io.full_o), 64'(v.e_full));
        chk($sformatf("v%0d.empty", k), 64'(io.empty_o), 64'(v.e_empty));
        chk($sformatf("v%0d.error", k), 64'(io.error_o), 64'(v.e_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".empty"},       64'(io.empty_o),       64'(1));
        chk({tag, ".full"},        64'(io.full_o),        64'(0));
        chk({tag, ".busy"},        64'(io.busy_o),        64'(0));
        chk({tag, ".sched_v"},     64'(io.sched_v_o),     64'(0));
        chk({tag, ".alloc_ready"}, 64'(io.alloc_ready_o), 64'(0));
        chk({tag, ".alloc_id"},    64'(io.alloc_id_o),    64'(0));
        chk({tag, ".active_id"},   64'(io.active_id_o),   64'(0));
        chk({tag, ".error"},       64'(io.error_o),       64'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //            a_v pa        lce yu su dn rv rid  ar aid sv sid spa       slc bsy act fu em er
        vecs[0]  = mk(1, 'h1000,   2,  0, 0, 0, 0, 0,   1, 0,  0, 0,  0,       0,  0,  0,  0, 1, 0);
        vecs[1]  = mk(0, 0,        0,  1, 0, 0, 0, 0,   1, 1,  1, 0,  'h1000,  2,  0,  0,  0, 0, 0);
        vecs[2]  = mk(1, 'h1020,   4,  0, 0, 0, 0, 0,   0, 1,  0, 0,  0,       0,  1,  0,  0, 0, 0);
        vecs[3]  = mk(1, 'h1040,   3,  0, 0, 0, 0, 0,   1, 1,  0, 0,  0,       0,  1,  0,  0, 0, 0);
        vecs[4]  = mk(1, 'h2000,   1,  0, 0, 0, 0, 0,   1, 2,  0, 0,  0,       0,  1,  0,  0, 0, 0);
        vecs[5]  = mk(1, 'h3000,   0,  0, 0, 0, 0, 0,   1, 3,  0, 0,  0,       0,  1,  0,  0, 0, 0);
        vecs[6]  = mk(1, 'h4000,   9,  0, 0, 1, 0, 0,   0, 0,  0, 0,  0,       0,  1,  0,  1, 0, 0);
        vecs[7]  = mk(0, 0,        0,  1, 0, 0, 0, 0,   1, 0,  1, 1,  'h1040,  3,  0,  0,  0, 0, 0);
        vecs[8]  = mk(0, 0,        0,  0, 1, 0, 0, 0,   1, 0,  0, 0,  0,       0,  1,  1,  0, 0, 0);
        vecs[9]  = mk(0, 0,        0,  1, 0, 0, 0, 0,   1, 0,  1, 2,  'h2000,  1,  0,  0,  0, 0, 0);
        vecs[10] = mk(0, 0,        0,  0, 0, 1, 1, 1,   1, 0,  0, 0,  0,       0,  1,  2,  0, 0, 0);
        vecs[11] = mk(0, 0,        0,  1, 0, 0, 0, 0,   1, 0,  1, 3,  'h3000,  0,  0,  0,  0, 0, 0);
        vecs[12] = mk(0, 0,        0,  0, 0, 1, 0, 0,   1, 0,  0, 0,  0,       0,  1,  3,  0, 0, 0);
        vecs[13] = mk(0, 0,        0,  1, 0, 0, 0, 0,   1, 0,  1, 1,  'h1040,  3,  0,  0,  0, 0, 0);
        vecs[14] = mk(0, 0,        0,  0, 0, 1, 0, 0,   1, 0,  0, 0,  0,       0,  1,  1,  0, 0, 0);
        vecs[15] = mk(1, 'h5000,   5,  0, 0, 0, 0, 0,   1, 0,  0, 0,  0,       0,  0,  0,  0, 1, 0);
        vecs[16] = mk(1, 'h6000,   6,  0, 0, 0, 0, 0,   1, 1,  1, 0,  'h5000,  5,  0,  0,  0, 0, 0);
        vecs[17] = mk(1, 'h7000,   7,  0, 0, 0, 0, 0,   1, 2,  1, 0,  'h5000,  5,  0,  0,  0, 0, 0);
        vecs[18] = mk(0, 0,        0,  1, 0, 0, 0, 0,   1, 3,  1, 2,  'h7000,  7,  0,  0,  0, 0, 0);
        vecs[19] = mk(0, 0,        0,  0, 0, 1, 0, 0,   1, 3,  0, 0,  0,       0,  1,  2,  0, 0, 0);
        vecs[20] = mk(0, 0,        0,  1, 0, 0, 0, 0,   1, 2,  1, 0,  'h5000,  5,  0,  0,  0, 0, 0);
        vecs[21] = mk(0, 0,        0,  0, 0, 1, 0, 0,   1, 2,  0, 0,  0,       0,  1,  0,  0, 0, 0);
        vecs[22] = mk(0, 0,        0,  1, 0, 0, 0, 0,   1, 0,  1, 1,  'h6000,  6,  0,  0,  0, 0, 0);
        vecs[23] = mk(0, 0,        0,  0, 0, 1, 0, 0,   1, 0,  0, 0,  0,       0,  1,  1,  0, 0, 0);
        vecs[24] = mk(0, 0,        0,  0, 0, 0, 0, 0,   1, 0,  0, 0,  0,       0,  0,  0,  0, 1, 0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset0");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(vecs[k]);
            #1;
            check_vec(k, vecs[k]);
        end

        // Suspend and response to the same slot in one cycle: suspend wins, response is early.
        step(1, 'h8000, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("c.sched_v", 64'(io.sched_v_o), 64'(1));
        chk("c.sched_id", 64'(io.sched_id_o), 64'(0));
        step(0, 0, 0, 0, 1, 0, 1, 0);
        chk("c.busy_pre", 64'(io.busy_o), 64'(1));
        chk("c.err_pre", 64'(io.error_o), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c.busy_post", 64'(io.busy_o), 64'(0));
        chk("c.err_post", 64'(io.error_o), 64'(1));
        chk("c.sched_v_wait", 64'(io.sched_v_o), 64'(0));
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c.rearm_v", 64'(io.sched_v_o), 64'(1));
        chk("c.rearm_id", 64'(io.sched_id_o), 64'(0));
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c.run_busy", 64'(io.busy_o), 64'(1));
        do_reset("midreset");

        // Response to a FREE slot.
        step(0, 0, 0, 0, 0, 0, 1, 2);
        chk("e1.err_pre", 64'(io.error_o), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("e1.err_post", 64'(io.error_o), 64'(1));
        do_reset("reset1");

        // done and suspend together: slot is freed and the error is flagged.
        step(1, 'h1000, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("e2.busy_pre", 64'(io.busy_o), 64'(1));
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("e2.empty", 64'(io.empty_o), 64'(1));
        chk("e2.busy", 64'(io.busy_o), 64'(0));
        chk("e2.err", 64'(io.error_o), 64'(1));
        do_reset("reset2");

        // Grant acknowledge with nothing offered; error stays sticky.
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("e3.sched_v", 64'(io.sched_v_o), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("e3.err", 64'(io.error_o), 64'(1));
        for (int j = 0; j < 3; j++) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("e3.err_sticky", 64'(io.error_o), 64'(1));
        chk("e3.empty", 64'(io.empty_o), 64'(1));
        do_reset("reset3");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
